// File: rtl/divide_32_seq.sv
// ---------------------------------------------------------------------------
// divide_32_seq
//   Multi-cycle unsigned restoring divider. Produces one quotient bit per
//   clock. One operation is in flight at a time. A request is taken with a
//   valid/ready handshake, and the result is held with a valid/ready handshake.
//
// Ports
//   clk          in   1      system clock, rising edge
//   rst_n        in   1      asynchronous active-low reset
//   req_valid    in   1      requester presents dividend/divisor
//   req_ready    out  1      high in IDLE; a request is accepted on this edge
//   dividend     in   WIDTH  unsigned a, sampled on accept
//   divisor      in   WIDTH  unsigned b, sampled on accept
//   resp_valid   out  1      result valid (DONE)
//   resp_ready   in   1      consumer takes the result
//   quotient     out  WIDTH  a / b (all ones when b == 0)
//   remainder    out  WIDTH  a % b (a when b == 0)
//   div_by_zero  out  1      divisor was zero for the current result
//   busy         out  1      iterating (BUSY)
// ---------------------------------------------------------------------------
module divide_32_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem_q;      // partial remainder
    logic [WIDTH-1:0] q_sr;       // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] div_q;      // latched divisor
    logic             zero_pend;  // current operation is a divide-by-zero

    logic             accept;
    logic             last_step;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             ge;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_q;

    assign accept    = (state == IDLE) && req_valid;
    assign last_step = (cnt == LAST_STEP);

    // ---------------- state register ----------------
    // NOTE: sequential state is written only with non-blocking assignments so
    // every flop samples values from before the edge, whatever the block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // ---------------- next-state logic ----------------
    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (req_valid)  state_next = BUSY;
            BUSY:    if (last_step)  state_next = DONE;
            DONE:    if (resp_ready) state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // ---------------- outputs decoded from registered state ----------------
    always_comb begin
        req_ready  = (state == IDLE);
        busy       = (state == BUSY);
        resp_valid = (state == DONE);
    end

    // ---------------- restoring step ----------------
    // The shifted remainder is one bit wider than the operands. Because
    // rem_q < div_q, the shifted value is < 2*div_q. The subtract therefore
    // never loses a carry, and its sign bit is the compare result.
    always_comb begin
        shifted  = {rem_q, q_sr[WIDTH-1]};
        diff     = shifted - {1'b0, div_q};
        ge       = ~diff[WIDTH];
        step_rem = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        step_q   = {q_sr[WIDTH-2:0], ge};
    end

    // ---------------- datapath ----------------
    // A zero divisor still passes through BUSY, but only for a single cycle.
    // The counter is preloaded to the last step, so the response appears one
    // cycle after accept.
    // NOTE: every datapath register is asynchronously reset. This way an
    // operation cut short by reset leaves no stale result or partial state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            rem_q       <= '0;
            q_sr        <= '0;
            div_q       <= '0;
            zero_pend   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            div_q     <= divisor;
            rem_q     <= '0;
            q_sr      <= dividend;
            zero_pend <= (divisor == '0);
            cnt       <= (divisor == '0) ? LAST_STEP : '0;
            if (divisor != '0) div_by_zero <= 1'b0;
        end else if (state == BUSY) begin
            cnt   <= cnt + 1'b1;
            rem_q <= step_rem;
            q_sr  <= step_q;
            if (last_step) begin
                quotient    <= zero_pend ? '1 : step_q;
                remainder   <= zero_pend ? q_sr : step_rem;
                div_by_zero <= zero_pend;
            end
        end
    end

endmodule

// File: tb/tb_divide_32_seq.sv
// ---------------------------------------------------------------------------
// tb_divide_32_seq
//   Directed bench for divide_32_seq (WIDTH = 32). Expected values are either
//   hand-computed constants or derived from the simulator's own / and %.
// ---------------------------------------------------------------------------
module tb_divide_32_seq;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         resp_valid;
    logic         resp_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         busy;

    int checks = 0;
    int fails  = 0;

    divide_32_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present a request and leave the bench 1 time unit after the accept edge.
    // The inputs are then scrambled to show they are not re-sampled.
    task automatic issue(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        check({tag, " req_ready before accept"}, 64'(req_ready), 64'(1));
        dividend  = a;
        divisor   = b;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        dividend  = ~a;
        divisor   = b ^ 32'h0000_0005;
    endtask

    task automatic await_resp(input string tag, input int exp_lat);
        int lat;
        lat = 0;
        while (resp_valid !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] q,
                                input logic [W-1:0] r, input logic dbz);
        check({tag, " quotient"},    64'(quotient),    64'(q));
        check({tag, " remainder"},   64'(remainder),   64'(r));
        check({tag, " div_by_zero"}, 64'(div_by_zero), 64'(dbz));
    endtask

    task automatic release_resp(input string tag, input int stall);
        repeat (stall) @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check({tag, " resp_valid after release"}, 64'(resp_valid), 64'(0));
        check({tag, " req_ready after release"},  64'(req_ready),  64'(1));
    endtask

    // Full operation with an independent model: a/b, a%b, or the div-by-zero rule.
    task automatic run_op(input string tag, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int stall);
        logic [W-1:0] eq, er;
        logic         ed;
        int           el;
        if (b == '0) begin
            eq = '1; er = a; ed = 1'b1; el = 1;
        end else begin
            eq = a / b; er = a % b; ed = 1'b0; el = W;
        end
        issue(tag, a, b);
        await_resp(tag, el);
        check_result(tag, eq, er, ed);
        release_resp(tag, stall);
    endtask

    initial begin
        logic [W-1:0] q_hold;
        logic [W-1:0] r_hold;
        logic         stray;

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        dividend   = '0;
        divisor    = '0;

        // Reset state
        #12;
        check("reset resp_valid",  64'(resp_valid),  64'(0));
        check("reset busy",        64'(busy),        64'(0));
        check("reset quotient",    64'(quotient),    64'(0));
        check("reset remainder",   64'(remainder),   64'(0));
        check("reset div_by_zero", 64'(div_by_zero), 64'(0));
        check("reset req_ready",   64'(req_ready),   64'(1));
        @(negedge clk);
        rst_n = 1'b1;

        // 1. 100 / 7 with exact latency and busy during iteration
        issue("t1 100/7", 32'd100, 32'd7);
        check("t1 busy after accept",     64'(busy),      64'(1));
        check("t1 req_ready after accept", 64'(req_ready), 64'(0));
        await_resp("t1 100/7", 32);
        check_result("t1 100/7", 32'd14, 32'd2, 1'b0);
        check("t1 busy in done", 64'(busy), 64'(0));
        release_resp("t1 100/7", 0);

        // 2. Extremes
        run_op("t2 max/1",      32'hFFFF_FFFF, 32'd1,         0);
        run_op("t2 msb/max",    32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("t2 0/13",       32'd0,         32'd13,        0);
        run_op("t2 small/big",  32'd17,        32'd1000,      1);

        // 3. Divide by zero, then a normal op clears the flag
        issue("t3 5/0", 32'd5, 32'd0);
        await_resp("t3 5/0", 1);
        check_result("t3 5/0", 32'hFFFF_FFFF, 32'd5, 1'b1);
        release_resp("t3 5/0", 0);
        run_op("t3 9/3", 32'd9, 32'd3, 0);

        // 4. Backpressure in DONE, with req_valid pulses that must be ignored
        issue("t4 200/9", 32'd200, 32'd9);
        await_resp("t4 200/9", 32);
        q_hold = quotient;
        r_hold = remainder;
        check("t4 quotient",  64'(q_hold), 64'(22));
        check("t4 remainder", 64'(r_hold), 64'(2));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            req_valid = i[0];
            dividend  = 32'd77 + 32'(i);
            divisor   = 32'd1;
            check("t4 hold resp_valid", 64'(resp_valid), 64'(1));
            check("t4 hold req_ready",  64'(req_ready),  64'(0));
            check("t4 hold quotient",   64'(quotient),   64'(q_hold));
            check("t4 hold remainder",  64'(remainder),  64'(r_hold));
        end
        @(negedge clk);
        req_valid = 1'b0;
        release_resp("t4 200/9", 0);
        check("t4 idle busy", 64'(busy), 64'(0));

        // 5. Reset at iteration 10 of 1000/3
        issue("t5 1000/3 aborted", 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5 reset resp_valid",  64'(resp_valid),  64'(0));
        check("t5 reset busy",        64'(busy),        64'(0));
        check("t5 reset quotient",    64'(quotient),    64'(0));
        check("t5 reset remainder",   64'(remainder),   64'(0));
        check("t5 reset div_by_zero", 64'(div_by_zero), 64'(0));
        check("t5 reset req_ready",   64'(req_ready),   64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        stray = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) stray = 1'b1;
        end
        check("t5 no stray resp_valid", 64'(stray), 64'(0));
        check("t5 req_ready idle",      64'(req_ready), 64'(1));
        run_op("t5 1000/3", 32'd1000, 32'd3, 0);

        // 6. Mixed operand mix with random response stalls
        for (int i = 0; i < 20; i++) begin
            logic [W-1:0] a, b;
            a = $urandom;
            if (i % 5 == 0)      b = '0;
            else if (i % 3 == 0) b = 32'($urandom_range(1, 255));
            else                 b = $urandom;
            run_op("t6 random", a, b, int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
